// File: rtl/norm_round_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : norm_round_pipe_if
// Upstream beat and downstream result bundle for norm_round_pipe.
// Rev    : 1.0
// ============================================================================
interface norm_round_pipe_if #(
    parameter int EXP  = 8,
    parameter int MANT = 23,
    parameter int MW   = 3*MANT+5,
    parameter int RM_W = 3
);
    logic                valid_i;
    logic                ready_o;
    logic [MW-1:0]       mant_i;
    logic [EXP+1:0]      exp_i;
    logic                sign_i;
    logic                sticky_i;
    logic [RM_W-1:0]     rm_i;
    logic                nan_i;
    logic                invalid_i;
    logic                inf_i;
    logic                valid_o;
    logic                ready_i;
    logic [EXP+MANT:0]   result_o;
    logic [4:0]          fflags_o;

    modport slave (
        input  valid_i, mant_i, exp_i, sign_i, sticky_i, rm_i,
               nan_i, invalid_i, inf_i, ready_i,
        output ready_o, valid_o, result_o, fflags_o
    );

    modport master (
        output valid_i, mant_i, exp_i, sign_i, sticky_i, rm_i,
               nan_i, invalid_i, inf_i, ready_i,
        input  ready_o, valid_o, result_o, fflags_o
    );
endinterface
`default_nettype wire

// File: rtl/norm_round_pipe.sv
`default_nettype none
// ============================================================================
// Module : norm_round_pipe
// Two-stage FMA normalise (S1) and round/pack (S2) with valid/ready handshake.
// Define NORM_ROUND_FTZ_EN to flush subnormal results to signed zero.
// Rev    : 1.0
// ============================================================================
module norm_round_pipe #(
    parameter int EXP  = 8,
    parameter int MANT = 23,
    parameter int MW   = 3*MANT+5,
    parameter int RM_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    norm_round_pipe_if.slave bus
);
    localparam int C_WW  = MW + 1;
    localparam int C_GP  = C_WW - MANT - 2;
    localparam int C_LZW = $clog2(MW + 1);
    localparam int C_EW  = EXP + 2;
    localparam int C_XW  = C_EW + C_LZW;
    localparam int C_RW  = 1 + EXP + MANT;

    localparam logic [RM_W-1:0] C_RTZ = RM_W'(1);
    localparam logic [RM_W-1:0] C_RDN = RM_W'(2);
    localparam logic [RM_W-1:0] C_RUP = RM_W'(3);
    localparam logic [RM_W-1:0] C_RMM = RM_W'(4);

    localparam logic signed [C_XW-1:0] C_X_ONE  = C_XW'(1);
    localparam logic signed [C_XW-1:0] C_X_EMAX = C_XW'(2**EXP);

    typedef struct packed {
        logic [C_WW-1:0] mag;
        logic [C_EW-1:0] e;
        logic            tiny;
        logic            stk;
        logic            sign;
        logic [RM_W-1:0] rm;
        logic            nan;
        logic            inv;
        logic            inf;
        logic            zero;
    } s1_t;

    logic            v1_q, v1_d, v2_q, v2_d;
    s1_t             s1_q, s1_d;
    logic [C_RW-1:0] result_q, result_d;
    logic [4:0]      fflags_q, fflags_d;
    logic            w_ready, w_accept, w_s2_load;

    assign w_ready      = ~v1_q | ~v2_q | bus.ready_i;
    assign w_accept     = bus.valid_i & w_ready;
    assign w_s2_load    = ~v2_q | bus.ready_i;
    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = v2_q;
    assign bus.result_o = result_q;
    assign bus.fflags_o = fflags_q;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (w_s2_load) begin
            v2_d = v1_q;
            v1_d = 1'b0;
        end
        if (w_accept) begin
            v1_d = 1'b1;
        end
    end

    // ---------------- S1: normalise ----------------
    logic [C_LZW-1:0]       w_lz;
    logic [C_WW-1:0]        w_ext, w_sub;
    logic signed [C_XW-1:0] w_e_norm;
    logic [C_XW-1:0]        w_sh;

    always_comb begin
        w_lz = C_LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (bus.mant_i[i]) begin
                w_lz = C_LZW'(MW - 1 - i);
            end
        end
    end

    // Widened by one LSB so the integer bit lands at C_WW-1 for any input with a leading one.
    assign w_ext    = {bus.mant_i, 1'b0} << w_lz;
    assign w_e_norm = {{C_LZW{bus.exp_i[C_EW-1]}}, bus.exp_i} + C_X_ONE - {{C_EW{1'b0}}, w_lz};
    assign w_sh     = C_X_ONE - w_e_norm;
    assign w_sub    = w_ext >> w_sh;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.sign_i;
        s1_d.rm   = bus.rm_i;
        s1_d.nan  = bus.nan_i;
        s1_d.inv  = bus.invalid_i;
        s1_d.inf  = bus.inf_i;
        s1_d.zero = ~|bus.mant_i;
        s1_d.stk  = bus.sticky_i;
        if (w_e_norm < C_X_ONE) begin
            s1_d.mag  = w_sub;
            s1_d.e    = C_EW'(1);
            s1_d.tiny = 1'b1;
            s1_d.stk  = bus.sticky_i | ((w_sub << w_sh) != w_ext);
        end else if (w_e_norm > C_X_EMAX) begin
            // Anything this large overflows anyway; clamping keeps e+1 in range.
            s1_d.mag = w_ext;
            s1_d.e   = C_EW'(2**EXP);
        end else begin
            s1_d.mag = w_ext;
            s1_d.e   = w_e_norm[C_EW-1:0];
        end
    end

    // ---------------- S2: round and pack ----------------
    logic [MANT:0]   w_keep, w_mant;
    logic [MANT+1:0] w_sum;
    logic [C_EW-1:0] w_e_rnd;
    logic            w_guard, w_stk, w_inexact, w_up, w_of, w_of_inf;

    assign w_keep    = s1_q.mag[C_WW-1 -: MANT+1];
    assign w_guard   = s1_q.mag[C_GP];
    assign w_stk     = (|s1_q.mag[C_GP-1:0]) | s1_q.stk;
    assign w_inexact = w_guard | w_stk;

    always_comb begin
        w_up     = w_guard & (w_stk | w_keep[0]);
        w_of_inf = 1'b1;
        case (s1_q.rm)
            C_RTZ: begin
                w_up     = 1'b0;
                w_of_inf = 1'b0;
            end
            C_RDN: begin
                w_up     = w_inexact & s1_q.sign;
                w_of_inf = s1_q.sign;
            end
            C_RUP: begin
                w_up     = w_inexact & ~s1_q.sign;
                w_of_inf = ~s1_q.sign;
            end
            C_RMM: begin
                w_up     = w_guard;
            end
            default: begin
                w_up     = w_guard & (w_stk | w_keep[0]);
            end
        endcase
    end

    assign w_sum   = {1'b0, w_keep} + {{(MANT+1){1'b0}}, w_up};
    assign w_mant  = w_sum[MANT+1] ? w_sum[MANT+1:1] : w_sum[MANT:0];
    assign w_e_rnd = s1_q.e + {{(C_EW-1){1'b0}}, w_sum[MANT+1]};
    assign w_of    = w_e_rnd >= C_EW'(2**EXP - 1);

    always_comb begin
        result_d = {s1_q.sign, (w_mant[MANT] ? w_e_rnd[EXP-1:0] : {EXP{1'b0}}), w_mant[MANT-1:0]};
        fflags_d = {3'b000, s1_q.tiny & w_inexact, w_inexact};
        if (w_of) begin
            fflags_d = 5'b00101;
            result_d = w_of_inf ? {s1_q.sign, {EXP{1'b1}}, {MANT{1'b0}}}
                                : {s1_q.sign, {(EXP-1){1'b1}}, 1'b0, {MANT{1'b1}}};
        end
`ifdef NORM_ROUND_FTZ_EN
        else if (!w_mant[MANT]) begin
            result_d = {s1_q.sign, {(C_RW-1){1'b0}}};
            fflags_d = 5'b00011;
        end
`endif
        if (s1_q.nan) begin
            result_d = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
            fflags_d = {s1_q.inv, 4'b0000};
        end else if (s1_q.inf) begin
            result_d = {s1_q.sign, {EXP{1'b1}}, {MANT{1'b0}}};
            fflags_d = {s1_q.inv, 4'b0000};
        end else if (s1_q.zero) begin
            result_d = {s1_q.sign, {(C_RW-1){1'b0}}};
            fflags_d = 5'b00000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            s1_q     <= '0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (w_accept) begin
                s1_q <= s1_d;
            end
            if (w_s2_load && v1_q) begin
                result_q <= result_d;
                fflags_q <= fflags_d;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_norm_round_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_norm_round_pipe
// Directed vectors for norm_round_pipe (binary32), handshake stall and reset.
// Rev    : 1.0
// ============================================================================
module tb_norm_round_pipe;
    localparam int EXP  = 8;
    localparam int MANT = 23;
    localparam int MW   = 3*MANT+5;
    localparam int RM_W = 3;

    localparam logic [MW-1:0] C_ONE = MW'(1) << (MW-2);
    localparam logic [MW-1:0] C_TWO = MW'(1) << (MW-1);
    localparam logic [MW-1:0] C_TIE = C_ONE | (MW'(1) << (MW-26));
    localparam logic [MW-1:0] C_ALL = MW'(25'h1FFFFFF) << (MW-26);

`ifdef NORM_ROUND_FTZ_EN
    localparam bit C_FTZ = 1'b1;
`else
    localparam bit C_FTZ = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    norm_round_pipe_if #(.EXP(EXP), .MANT(MANT), .MW(MW), .RM_W(RM_W)) bus ();

    norm_round_pipe #(.EXP(EXP), .MANT(MANT), .MW(MW), .RM_W(RM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input logic [MW-1:0] m, input logic [EXP+1:0] e, input logic s,
                            input logic st, input logic [RM_W-1:0] rm, input logic nan,
                            input logic inv, input logic inf);
        bus.mant_i    = m;
        bus.exp_i     = e;
        bus.sign_i    = s;
        bus.sticky_i  = st;
        bus.rm_i      = rm;
        bus.nan_i     = nan;
        bus.invalid_i = inv;
        bus.inf_i     = inf;
    endtask

    task automatic push(input string tag);
        logic acc;
        acc = 1'b0;
        bus.valid_i = 1'b1;
        for (int n = 0; n < 10 && !acc; n++) begin
            acc = bus.ready_o;
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        check({tag, "_acc"}, acc, 1);
    endtask

    task automatic run_vec(input string tag, input logic [MW-1:0] m, input logic [EXP+1:0] e,
                           input logic s, input logic st, input logic [RM_W-1:0] rm,
                           input logic nan, input logic inv, input logic inf,
                           input logic [31:0] res, input logic [4:0] fl);
        int lat;
        set_beat(m, e, s, st, rm, nan, inv, inf);
        push(tag);
        lat = 1;
        while (!bus.valid_o && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_res"}, bus.result_o, res);
        check({tag, "_flg"}, bus.fflags_o, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        set_beat('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.valid_o, 0);
        check("rst_result", bus.result_o, 0);
        check("rst_flags", bus.fflags_o, 0);
        check("rst_ready", bus.ready_o, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //       tag          mant   exp       s     st    rm    nan   inv   inf   result                    flags
        run_vec("one",       C_ONE, 10'd127,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000,             5'h00);
        run_vec("tie_rne",   C_TIE, 10'd127,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000,             5'h01);
        run_vec("tie_rmm",   C_TIE, 10'd127,  1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h3F800001,             5'h01);
        run_vec("tie_rup_n", C_TIE, 10'd127,  1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'hBF800000,             5'h01);
        run_vec("tie_rdn_n", C_TIE, 10'd127,  1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'hBF800001,             5'h01);
        run_vec("tie_rm7",   C_TIE, 10'd127,  1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 32'h3F800000,             5'h01);
        run_vec("carry",     C_ALL, 10'd127,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40000000,             5'h01);
        run_vec("cbit_in",   C_TWO, 10'd127,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40000000,             5'h00);
        run_vec("of_rne",    C_ONE, 10'd255,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000,             5'h05);
        run_vec("of_rtz",    C_ONE, 10'd255,  1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF,             5'h05);
        run_vec("of_rdn_p",  C_ONE, 10'd255,  1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF,             5'h05);
        run_vec("of_rup_p",  C_ONE, 10'd255,  1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h7F800000,             5'h05);
        run_vec("sub_ex",    C_ONE, 10'h3EA,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, C_FTZ ? 32'h0 : 32'h1,  C_FTZ ? 5'h03 : 5'h00);
        run_vec("sub_stk",   C_ONE, 10'h3EA,  1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, C_FTZ ? 32'h0 : 32'h1,  5'h03);
        run_vec("sub_to_nr", C_ALL, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00800000,             5'h03);
        run_vec("deep_rne",  C_ONE, 10'h338,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000000,             5'h03);
        run_vec("deep_rup",  C_ONE, 10'h338,  1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, C_FTZ ? 32'h0 : 32'h1,  5'h03);
        run_vec("nan",       C_ONE, 10'd127,  1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 32'h7FC00000,             5'h10);
        run_vec("inf_n",     C_ONE, 10'd127,  1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'hFF800000,             5'h00);
        run_vec("zero_n",    '0,    10'd127,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80000000,             5'h00);

        // Four beats back-to-back, then a three-cycle downstream stall.
        bus.ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(C_ONE, 10'(127 + k), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            push($sformatf("hs_in%0d", k));
            if (k > 0) begin
                check($sformatf("hs_v%0d", k - 1), bus.valid_o, 1);
                check($sformatf("hs_out%0d", k - 1), bus.result_o, 32'h3F800000 + (32'(k - 1) << 23));
            end
        end
        bus.ready_i = 1'b0;
        #1;
        check("hs_full_ready", bus.ready_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hs_stall_v%0d", c), bus.valid_o, 1);
            check($sformatf("hs_stall_res%0d", c), bus.result_o, 32'h40800000);
            check($sformatf("hs_stall_rdy%0d", c), bus.ready_o, 0);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("hs_out3_v", bus.valid_o, 1);
        check("hs_out3", bus.result_o, 32'h41000000);
        @(posedge clk);
        #1;
        check("hs_drained", bus.valid_o, 0);

        // Reset asserted while both stages hold stalled beats.
        bus.ready_i = 1'b0;
        set_beat(C_ONE, 10'd127, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("rs_in0");
        set_beat(C_ONE, 10'd128, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("rs_in1");
        check("rs_full_ready", bus.ready_o, 0);
        check("rs_full_valid", bus.valid_o, 1);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_valid", bus.valid_o, 0);
        check("rs_result", bus.result_o, 0);
        check("rs_flags", bus.fflags_o, 0);
        check("rs_ready", bus.ready_o, 1);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rs_stale%0d", c), bus.valid_o, 0);
        end
        run_vec("post_rst",  C_TIE, 10'd127,  1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h3F800001,             5'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/norm_round_pipe.md
Name: norm_round_pipe

Overview:
Parametrised, pipelined successor to the combinational FMA normalise-and-round stage. Takes a signed-exponent, unnormalised wide magnitude from the adder/LZA path and normalises it. Rounds to any IEEE-754 binary format in all five RISC-V rounding modes, including RMM and correct sign-dependent RDN/RUP, and produces packed result plus fflags. Sits between the FMA adder and the writeback register, with valid/ready handshake on both sides.

Parameters:
EXP, 8, exponent field width
MANT, 23, stored fraction width
MW, 3*MANT+5, input magnitude width; bit MW-1 is carry bit, integer bit is MW-2
RM_W, 3, rounding-mode width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_i  in  1  input beat valid
ready_o  out  1  block can accept a beat
mant_i  in  MW  unnormalised magnitude; value = mant_i/2^(MW-2) * 2^(exp_i-BIAS), where BIAS=2^(EXP-1)-1
exp_i  in  EXP+2  two's-complement biased exponent
sign_i  in  1  result sign
sticky_i  in  1  OR of bits already discarded upstream
rm_i  in  RM_W  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, others treated as RNE
nan_i  in  1  result is NaN
invalid_i  in  1  raise NV
inf_i  in  1  result is exact infinity of sign_i
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts
result_o  out  1+EXP+MANT  packed {sign, exp, frac}
fflags_o  out  5  {NV, DZ, OF, UF, NX}; DZ always 0

Behaviour:
- Two registered stages, S1 and S2. Latency is 2 cycles from an accepted input to valid_o when unstalled. Throughput is 1 beat/cycle.
- Handshake: input accepted when valid_i & ready_o. ready_o = ~v1 | ~v2 | ready_i, where v1/v2 are the stage-valid bits. S2 loads from S1 when ~v2 | ready_i. Output holds stable while valid_o & ~ready_i. No beat is dropped or duplicated.
- Reset (async, any time, including mid-stall): v1=v2=0, valid_o=0, result_o=0, fflags_o=0. In-flight beats are discarded.
- S1 (normalise):
  - Leading-one detect on mant_i; LZ counts from bit MW-1.
  - Normal target: leading one at MW-2; e = exp_i + 1 - LZ.
  - If e < 1: shift so e = 1 (subnormal), set tiny. A shift of MW or more leaves all bits in sticky.
  - mant_i == 0 and not special gives zero.
  - Register the shifted magnitude, e (EXP+2 bits), tiny, specials, sign, rm, and sticky.
- S2 (round):
  - Keep = integer bit + MANT fraction bits. Guard = next bit. Sticky = OR of lower bits | sticky_i.
  - Round-up by mode:
    - RNE: G&(S|L)
    - RTZ: 0
    - RDN: (G|S)&sign
    - RUP: (G|S)&~sign
    - RMM: G
  - Carry-out renormalises: shift right 1, e+1.
  - Subnormal rounding up into the integer bit gives e=1 normal.
  - Final e = 0 field when integer bit is 0.
- Overflow: e >= 2^EXP-1 after rounding sets OF and NX. Result is infinity for RNE/RMM, for RUP with +, and for RDN with -. Otherwise it is the largest finite of sign_i.
- UF = tiny & inexact (tininess before rounding). NX = G|S or overflow.
- Priority: nan_i > inf_i > zero > finite.
  - NaN gives canonical {0, all-ones, 1 followed by zeros}, NV = invalid_i, other flags 0.
  - Inf gives signed infinity with no flags except NV = invalid_i.
  - Zero gives signed zero with flags 0.

Optional Feature:
NORM_ROUND_FTZ_EN. When defined, any finite result that would be subnormal after rounding is flushed to signed zero, with UF=1 and NX=1. When undefined, subnormals are produced per IEEE as above. Latency and handshake are the same either way.

Test Plan:
- 1.0: mant_i=1<<(MW-2), exp_i=127, RNE, binary32 -> two cycles later result_o=0x3F800000, fflags=0.
- Tie: mant 1+2^-24, exp_i=127 -> RNE 0x3F800000 with NX; RMM 0x3F800001 with NX; RUP with sign=1 gives 0xBF800000 with NX.
- Overflow: mant 1.0, exp_i=255 -> RNE 0x7F800000 with OF|NX; RTZ 0x7F7FFFFF with OF|NX; RDN with sign=0 gives 0x7F7FFFFF.
- Subnormal:
  - mant 1.0, exp_i=-22 -> 0x00000001, fflags=0.
  - Same plus sticky_i=1 -> 0x00000001 with UF|NX.
  - With FTZ_EN -> 0x00000000 with UF|NX.
- Specials:
  - nan_i=1, invalid_i=1 -> 0x7FC00000 with NV.
  - inf_i=1, sign=1 -> 0xFF800000.
  - mant_i=0, sign=1 -> 0x80000000.
- Handshake: stream 4 beats back-to-back, then ready_i=0 for 3 cycles -> result_o stable, ready_o=0 once both stages are full, all 4 results in order. Assert rst mid-stall -> valid_o=0 next edge, no stale output after release.
